// File: rtl/counter_sync_if.sv
// Status bundle of counter_sync: the counter drives it through the master
// modport and observers read it through the slave modport.
interface counter_sync_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             wrapped;
  logic [15:0]      wrap_count;

  modport master (output count, at_max, wrapped, wrap_count);
  modport slave  (input  count, at_max, wrapped, wrap_count);
endinterface

// File: rtl/counter_sync.sv
// Free-running synchronous up-counter with configurable step and modulus.
// Define COUNTER_SYNC_SATURATE_EN to clamp at the top value instead of wrapping.
module counter_sync #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [64:0] INIT    = 65'd0,
  parameter logic [64:0] STEP    = 65'd1,
  parameter logic [64:0] MODULUS = 65'd0
) (
  input  logic           clk,
  input  logic           rst,
  counter_sync_if.master cnt
);

  // A modulus of zero selects the natural 2^WIDTH roll-over.
  localparam logic [64:0] MAXV_FULL = (MODULUS == 65'd0) ? ((65'd1 << WIDTH) - 65'd1)
                                                         : (MODULUS - 65'd1);
  localparam logic [WIDTH:0]   MAXV_W = MAXV_FULL[WIDTH:0];
  localparam logic [WIDTH:0]   STEP_W = STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];
`ifndef COUNTER_SYNC_SATURATE_EN
  localparam logic [64:0]      MOD_FULL = MAXV_FULL + 65'd1;
  localparam logic [WIDTH:0]   MOD_W    = MOD_FULL[WIDTH:0];
`endif

  if (WIDTH < 1 || WIDTH > 64) begin : g_badWidth
    $error("counter_sync: WIDTH must be in 1..64");
  end
  if (MODULUS != 65'd0 && (MODULUS < 65'd2 || MODULUS > (65'd1 << WIDTH))) begin : g_badModulus
    $error("counter_sync: MODULUS must be 0 or in 2..2^WIDTH");
  end
  if (INIT > MAXV_FULL) begin : g_badInit
    $error("counter_sync: INIT must be below the modulus");
  end
  if (STEP == 65'd0 || STEP > MAXV_FULL) begin : g_badStep
    $error("counter_sync: STEP must be in 1..modulus-1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [15:0]      wrapCount_q, wrapCount_d;
  logic [WIDTH:0]   sum;
  logic             overflow;

  // One extra bit keeps the carry so the compare against MAXV is exact.
  assign sum      = {1'b0, count_q} + STEP_W;
  assign overflow = (sum > MAXV_W);

`ifdef COUNTER_SYNC_SATURATE_EN
  always_comb begin
    count_d     = sum[WIDTH-1:0];
    wrapped_d   = 1'b0;
    wrapCount_d = wrapCount_q;
    if (overflow) begin
      count_d = MAXV_W[WIDTH-1:0];
    end
  end
`else
  logic [WIDTH:0] sumWrapped;

  assign sumWrapped = sum - MOD_W;

  always_comb begin
    count_d     = sum[WIDTH-1:0];
    wrapped_d   = 1'b0;
    wrapCount_d = wrapCount_q;
    if (overflow) begin
      count_d   = sumWrapped[WIDTH-1:0];
      wrapped_d = 1'b1;
      if (wrapCount_q != 16'hFFFF) begin
        wrapCount_d = wrapCount_q + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= INIT_W;
      wrapped_q   <= 1'b0;
      wrapCount_q <= 16'd0;
    end else begin
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      wrapCount_q <= wrapCount_d;
    end
  end

  assign cnt.count      = count_q;
  assign cnt.at_max     = overflow;
  assign cnt.wrapped    = wrapped_q;
  assign cnt.wrap_count = wrapCount_q;

endmodule

// File: tb/tb_counter_sync.sv
// Self-checking bench for counter_sync: six configurations share one clock and reset,
// checked by a vector table, directed sequences and a closed-form reference model.
module tb_counter_sync;

  logic clk;
  logic rst;

  counter_sync_if #(.WIDTH(32)) if0 ();
  counter_sync_if #(.WIDTH(4))  if1 ();
  counter_sync_if #(.WIDTH(8))  if2 ();
  counter_sync_if #(.WIDTH(8))  if3 ();
  counter_sync_if #(.WIDTH(4))  if4 ();
  counter_sync_if #(.WIDTH(1))  if5 ();

  counter_sync u0 (.clk(clk), .rst(rst), .cnt(if0));
  counter_sync #(.WIDTH(4), .INIT(65'd0), .STEP(65'd1), .MODULUS(65'd10))
    u1 (.clk(clk), .rst(rst), .cnt(if1));
  counter_sync #(.WIDTH(8), .INIT(65'd250), .STEP(65'd3), .MODULUS(65'd0))
    u2 (.clk(clk), .rst(rst), .cnt(if2));
  counter_sync #(.WIDTH(8), .INIT(65'd1), .STEP(65'd255), .MODULUS(65'd0))
    u3 (.clk(clk), .rst(rst), .cnt(if3));
  counter_sync #(.WIDTH(4), .INIT(65'd0), .STEP(65'd4), .MODULUS(65'd0))
    u4 (.clk(clk), .rst(rst), .cnt(if4));
  counter_sync #(.WIDTH(1), .INIT(65'd0), .STEP(65'd1), .MODULUS(65'd0))
    u5 (.clk(clk), .rst(rst), .cnt(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rstIn;
    int c0;
    int c1;
    int a1;
    int w1;
    int wc1;
    int c2;
    int a2;
    int w2;
  } vec_t;

  int checks = 0;
  int failures = 0;
  longint unsigned k = 0;
  longint unsigned initTab[6] = '{64'd0, 64'd0, 64'd250, 64'd1, 64'd0, 64'd0};
  longint unsigned stepTab[6] = '{64'd1, 64'd1, 64'd3, 64'd255, 64'd4, 64'd1};
  longint unsigned modTab[6]  = '{64'h1_0000_0000, 64'd10, 64'd256, 64'd256, 64'd16, 64'd2};

  function automatic vec_t mkVec(int r, int c0, int c1, int a1, int w1, int wc1,
                                 int c2, int a2, int w2);
    vec_t v;
    v.rstIn = r; v.c0 = c0; v.c1 = c1; v.a1 = a1; v.w1 = w1; v.wc1 = wc1;
    v.c2 = c2; v.a2 = a2; v.w2 = w2;
    return v;
  endfunction

  // Closed form: after k counting edges the unbounded total is INIT + k*STEP.
  function automatic void refModel(input int idx, input longint unsigned kk,
                                   output longint unsigned c, output bit am,
                                   output bit wr, output longint unsigned wc);
    longint unsigned modv  = modTab[idx];
    longint unsigned maxv  = modv - 1;
    longint unsigned total = initTab[idx] + kk * stepTab[idx];
`ifdef COUNTER_SYNC_SATURATE_EN
    c  = (total > maxv) ? maxv : total;
    wr = 1'b0;
    wc = 0;
`else
    longint unsigned prev;
    c    = total % modv;
    wc   = total / modv;
    prev = (kk == 0) ? wc : (initTab[idx] + (kk - 1) * stepTab[idx]) / modv;
    wr   = (wc != prev);
    if (wc > 65535) wc = 65535;
`endif
    am = (c + stepTab[idx]) > maxv;
  endfunction

  task automatic getActual(input int idx, output longint unsigned c, output bit am,
                           output bit wr, output longint unsigned wc);
    case (idx)
      0: begin c = 64'(if0.count); am = if0.at_max; wr = if0.wrapped; wc = 64'(if0.wrap_count); end
      1: begin c = 64'(if1.count); am = if1.at_max; wr = if1.wrapped; wc = 64'(if1.wrap_count); end
      2: begin c = 64'(if2.count); am = if2.at_max; wr = if2.wrapped; wc = 64'(if2.wrap_count); end
      3: begin c = 64'(if3.count); am = if3.at_max; wr = if3.wrapped; wc = 64'(if3.wrap_count); end
      4: begin c = 64'(if4.count); am = if4.at_max; wr = if4.wrapped; wc = 64'(if4.wrap_count); end
      default: begin c = 64'(if5.count); am = if5.at_max; wr = if5.wrapped; wc = 64'(if5.wrap_count); end
    endcase
  endtask

  // Drives reset for one edge and samples 1 time unit after it.
  task automatic applyStimulus(input bit rstVal);
    rst = rstVal;
    @(posedge clk);
    #1;
    if (rstVal) k = 0;
    else        k++;
  endtask

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input int idx, input string tag);
    longint unsigned ec, ac, ewc, awc;
    bit eam, ewr, aam, awr;
    refModel(idx, k, ec, eam, ewr, ewc);
    getActual(idx, ac, aam, awr, awc);
    checks++;
    if (ac != ec || aam != eam || awr != ewr || awc != ewc) begin
      failures++;
      $display("[TB] FAIL %s_u%0d k=%0d actual c=%0d am=%0d w=%0d wc=%0d expected c=%0d am=%0d w=%0d wc=%0d",
               tag, idx, k, ac, aam, awr, awc, ec, eam, ewr, ewc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[13];
    int seqC[7];
    int seqA[7];
    int seqW[7];
    longint unsigned expWcSat;

`ifdef COUNTER_SYNC_SATURATE_EN
    vecs[0]  = mkVec(1,  0, 0, 0, 0, 0, 250, 0, 0);
    vecs[1]  = mkVec(0,  1, 1, 0, 0, 0, 253, 1, 0);
    vecs[2]  = mkVec(0,  2, 2, 0, 0, 0, 255, 1, 0);
    vecs[3]  = mkVec(0,  3, 3, 0, 0, 0, 255, 1, 0);
    vecs[4]  = mkVec(0,  4, 4, 0, 0, 0, 255, 1, 0);
    vecs[5]  = mkVec(0,  5, 5, 0, 0, 0, 255, 1, 0);
    vecs[6]  = mkVec(0,  6, 6, 0, 0, 0, 255, 1, 0);
    vecs[7]  = mkVec(0,  7, 7, 0, 0, 0, 255, 1, 0);
    vecs[8]  = mkVec(0,  8, 8, 0, 0, 0, 255, 1, 0);
    vecs[9]  = mkVec(0,  9, 9, 1, 0, 0, 255, 1, 0);
    vecs[10] = mkVec(0, 10, 9, 1, 0, 0, 255, 1, 0);
    vecs[11] = mkVec(0, 11, 9, 1, 0, 0, 255, 1, 0);
    vecs[12] = mkVec(0, 12, 9, 1, 0, 0, 255, 1, 0);
    seqC = '{0, 4, 8, 12, 15, 15, 15};
    seqA = '{0, 0, 0, 1, 1, 1, 1};
    seqW = '{0, 0, 0, 0, 0, 0, 0};
    expWcSat = 0;
`else
    vecs[0]  = mkVec(1,  0, 0, 0, 0, 0, 250, 0, 0);
    vecs[1]  = mkVec(0,  1, 1, 0, 0, 0, 253, 1, 0);
    vecs[2]  = mkVec(0,  2, 2, 0, 0, 0,   0, 0, 1);
    vecs[3]  = mkVec(0,  3, 3, 0, 0, 0,   3, 0, 0);
    vecs[4]  = mkVec(0,  4, 4, 0, 0, 0,   6, 0, 0);
    vecs[5]  = mkVec(0,  5, 5, 0, 0, 0,   9, 0, 0);
    vecs[6]  = mkVec(0,  6, 6, 0, 0, 0,  12, 0, 0);
    vecs[7]  = mkVec(0,  7, 7, 0, 0, 0,  15, 0, 0);
    vecs[8]  = mkVec(0,  8, 8, 0, 0, 0,  18, 0, 0);
    vecs[9]  = mkVec(0,  9, 9, 1, 0, 0,  21, 0, 0);
    vecs[10] = mkVec(0, 10, 0, 0, 1, 1,  24, 0, 0);
    vecs[11] = mkVec(0, 11, 1, 0, 0, 1,  27, 0, 0);
    vecs[12] = mkVec(0, 12, 2, 0, 0, 1,  30, 0, 0);
    seqC = '{0, 4, 8, 12, 0, 4, 8};
    seqA = '{0, 0, 0, 1, 0, 0, 0};
    seqW = '{0, 0, 0, 0, 1, 0, 0};
    expWcSat = 65535;
`endif

    rst = 1'b1;
    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rstIn != 0);
      checkOutput($sformatf("vec%0d_count_u0", i), 64'(if0.count), 64'(vecs[i].c0));
      checkOutput($sformatf("vec%0d_atmax_u0", i), 64'(if0.at_max), 64'd0);
      checkOutput($sformatf("vec%0d_wrapped_u0", i), 64'(if0.wrapped), 64'd0);
      checkOutput($sformatf("vec%0d_count_u1", i), 64'(if1.count), 64'(vecs[i].c1));
      checkOutput($sformatf("vec%0d_atmax_u1", i), 64'(if1.at_max), 64'(vecs[i].a1));
      checkOutput($sformatf("vec%0d_wrapped_u1", i), 64'(if1.wrapped), 64'(vecs[i].w1));
      checkOutput($sformatf("vec%0d_wrapcnt_u1", i), 64'(if1.wrap_count), 64'(vecs[i].wc1));
      checkOutput($sformatf("vec%0d_count_u2", i), 64'(if2.count), 64'(vecs[i].c2));
      checkOutput($sformatf("vec%0d_atmax_u2", i), 64'(if2.at_max), 64'(vecs[i].a2));
      checkOutput($sformatf("vec%0d_wrapped_u2", i), 64'(if2.wrapped), 64'(vecs[i].w2));
    end

    $display("[TB] reset mid-run");
    applyStimulus(1'b1);
    checkOutput("rst_atmax_u3", 64'(if3.at_max), 64'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0);
    checkOutput("midrun_count7_u0", 64'(if0.count), 64'd7);
    applyStimulus(1'b1);
    checkOutput("midrun_reset_u0", 64'(if0.count), 64'd0);
    checkOutput("midrun_wrapcnt_u1", 64'(if1.wrap_count), 64'd0);
    checkOutput("midrun_wrapped_u1", 64'(if1.wrapped), 64'd0);
    applyStimulus(1'b0);
    checkOutput("midrun_first_inc_u0", 64'(if0.count), 64'd1);

    $display("[TB] pending wrap discarded by reset");
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("pend_count_u2", 64'(if2.count), 64'd253);
    checkOutput("pend_atmax_u2", 64'(if2.at_max), 64'd1);
    applyStimulus(1'b1);
    checkOutput("pend_wrapped_u2", 64'(if2.wrapped), 64'd0);
    checkOutput("pend_count_reset_u2", 64'(if2.count), 64'd250);

    $display("[TB] step-4 sequence");
    applyStimulus(1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) applyStimulus(1'b0);
      checkOutput($sformatf("step4_%0d_count_u4", i), 64'(if4.count), 64'(seqC[i]));
      checkOutput($sformatf("step4_%0d_atmax_u4", i), 64'(if4.at_max), 64'(seqA[i]));
      checkOutput($sformatf("step4_%0d_wrapped_u4", i), 64'(if4.wrapped), 64'(seqW[i]));
      checkOutput($sformatf("step4_%0d_wrapcnt_u4", i), 64'(if4.wrap_count),
                  (i >= 4 && seqW[4] == 1) ? 64'd1 : 64'd0);
    end

    $display("[TB] randomized run against reference model");
    applyStimulus(1'b1);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 39) == 0);
      for (int d = 0; d < 6; d++) checkModel(d, "rand");
    end

    $display("[TB] wrap counter saturation");
    applyStimulus(1'b1);
    while (k < 65700) applyStimulus(1'b0);
    for (int d = 0; d < 6; d++) checkModel(d, "long_a");
    while (k < 65792) applyStimulus(1'b0);
    for (int d = 0; d < 6; d++) checkModel(d, "long_b");
    while (k < 66000) applyStimulus(1'b0);
    for (int d = 0; d < 6; d++) checkModel(d, "long_c");
    checkOutput("wrapcnt_hold_u3", 64'(if3.wrap_count), expWcSat);
    applyStimulus(1'b0);
    checkModel(3, "long_d");
    checkModel(5, "long_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sync.md
Name:
counter_sync

Overview:
- Free-running synchronous up-counter; increments by a fixed step on every clock edge once out of reset.
- Wraps at a configurable modulus (default: natural 2^WIDTH roll-over).
- Also reports terminal-count and wrap status.
- Used as a general timebase / cycle counter; the default configuration is a 32-bit cycle counter starting at 0.

Parameters:
- WIDTH, 32, counter width in bits (1..64).
- INIT, 0, value loaded by reset; must be < modulus.
- STEP, 1, increment per clock; 1 <= STEP < modulus.
- MODULUS, 0, 0 = natural wrap at 2^WIDTH; otherwise count range is 0..MODULUS-1 (2 <= MODULUS <= 2^WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- count  output  WIDTH  current count, registered.
- at_max  output  1  combinational; 1 when the next increment wraps (or saturates), i.e. count+STEP > MAXV.
- wrapped  output  1  registered one-cycle pulse; 1 in the cycle after a wrap occurred.
- wrap_count  output  16  registered number of wraps since reset; saturates at 16'hFFFF.

Behaviour:
- Single clock domain, all state on rising clk. Reset is synchronous and active-high: no asynchronous path.
- MAXV = 2^WIDTH-1 if MODULUS==0, else MODULUS-1.
- Reset (rst=1 at edge): count<=INIT, wrapped<=0, wrap_count<=0. Reset has priority over counting.
- Reset mid-operation: takes effect at the next edge regardless of count value; any pending wrap is discarded (wrapped=0 after that edge).
- No enable input: every non-reset edge advances the counter.
- First increment occurs on the first rising edge with rst=0, so latency from reset release to count=INIT+STEP is 1 edge.
- Next-value arithmetic is done in WIDTH+1 bits: sum = count + STEP.
  - If sum <= MAXV: count<=sum, wrapped<=0.
  - Else: count<=sum-(MAXV+1), wrapped<=1, wrap_count<=wrap_count+1 (held at 16'hFFFF once reached).
- Natural wrap example (WIDTH=8, STEP=3): 254 -> 1.
- Modulus wrap example (MODULUS=10, STEP=1): 9 -> 0.
- at_max is purely combinational from count. It is 1 exactly in the cycle before a wrap edge, and it is also 1 during reset if INIT+STEP > MAXV.
- Out-of-range parameters (INIT>MAXV, STEP=0, STEP>MAXV) are illegal; the design issues an elaboration-time $error.
- No X propagation requirement beyond reset: outputs are undefined only before the first reset edge.

Optional Feature:
- Macro COUNTER_SYNC_SATURATE_EN.
- Defined: no wrap. When sum > MAXV, count<=MAXV and holds there until reset. wrapped stays 0 and wrap_count stays 0. at_max=1 while count+STEP > MAXV, including while holding at MAXV.
- Undefined: wrap behaviour as above.

Test Plan:
- Default params, clk period 10, rst=1 for first edge then 0 for 10 edges -> count=0 after reset edge, then 1,2,...,10. Count is exactly 10 after the 10th post-reset edge; wrapped=0 and at_max=0 throughout.
- Reset mid-run: default params, count reaches 7, assert rst for one edge -> count=0 at that edge, then 1 on the next edge. wrap_count=0.
- Modulus wrap: WIDTH=4, MODULUS=10, STEP=1, run 25 edges -> sequence 0..9,0..9,0..4. at_max=1 when count=9. wrapped pulses in the cycles following the edges where 9->0 occurred. wrap_count=2 at the end.
- Natural wrap with step: WIDTH=8, INIT=250, STEP=3 -> 250,253,0,3,... at_max=1 at 253. wrapped=1 for exactly the one cycle with count=0.
- Saturation (COUNTER_SYNC_SATURATE_EN defined): WIDTH=4, STEP=4, INIT=0 -> 0,4,8,12,15,15,15. wrapped never 1, wrap_count=0, at_max=1 from count=12 onward.
- wrap_count saturation: WIDTH=1, STEP=1, run 140000 edges -> wrap_count holds 16'hFFFF, and count keeps toggling.
